// File: rtl/core_mem_pkg.sv
// Shared types for the core-to-memory arbiter: FSM state and transaction source encodings.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating performance counters for the memory arbiter (only built with MEM_ARB_PERF_EN).
module mem_arb_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_iGrant,
    input  logic             i_dGrant,
    input  logic             i_iStall,
    output logic [CNT_W-1:0] o_iGrants,
    output logic [CNT_W-1:0] o_dGrants,
    output logic [CNT_W-1:0] o_iStall
);

    logic [CNT_W-1:0] r_iGrants;
    logic [CNT_W-1:0] r_dGrants;
    logic [CNT_W-1:0] r_iStall;

    // Each counter sticks at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iGrants <= '0;
            r_dGrants <= '0;
            r_iStall  <= '0;
        end else begin
            if (i_iGrant && (r_iGrants != '1)) r_iGrants <= r_iGrants + 1'b1;
            if (i_dGrant && (r_dGrants != '1)) r_dGrants <= r_dGrants + 1'b1;
            if (i_iStall && (r_iStall  != '1)) r_iStall  <= r_iStall + 1'b1;
        end
    end

    assign o_iGrants = r_iGrants;
    assign o_dGrants = r_dGrants;
    assign o_iStall  = r_iStall;

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction fetches and data accesses onto one single-port memory bus, data first.
// Define MEM_ARB_PERF_EN to add saturating grant/stall performance counters.
module mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_i_grants,
    output logic [CNT_W-1:0] perf_d_grants,
    output logic [CNT_W-1:0] perf_i_stall
`endif
);

    arb_state_t    r_state;
    arb_src_t      r_src;
    logic          r_kill;
    logic          r_memReq;
    logic          r_memWe;
    logic [AW-1:0] r_memAddr;
    logic [DW-1:0] r_memWdata;
    logic [DW-1:0] r_iRdata;
    logic [DW-1:0] r_dRdata;

    logic w_dGrant;
    logic w_iGrant;
    logic w_iKilled;

    assign w_dGrant  = (r_state == IDLE) && d_req;
    assign w_iGrant  = (r_state == IDLE) && !d_req && i_req && !flush;
    assign w_iKilled = r_kill || flush;

    // Bus side is fully registered; a flush seen on the completing edge still kills the fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_src      <= SRC_I;
            r_kill     <= 1'b0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_iRdata   <= '0;
            r_dRdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dGrant) begin
                        r_state    <= D_BUSY;
                        r_src      <= SRC_D;
                        r_memReq   <= 1'b1;
                        r_memWe    <= d_we;
                        r_memAddr  <= d_addr;
                        r_memWdata <= d_wdata;
                    end else if (w_iGrant) begin
                        r_state   <= I_BUSY;
                        r_src     <= SRC_I;
                        r_memReq  <= 1'b1;
                        r_memWe   <= 1'b0;
                        r_memAddr <= i_addr;
                    end
                end
                I_BUSY: begin
                    if (flush) r_kill <= 1'b1;
                    if (mem_ack) begin
                        r_state  <= RESP;
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        if (!w_iKilled) r_iRdata <= mem_rdata;
                    end
                end
                D_BUSY: begin
                    if (mem_ack) begin
                        r_state  <= RESP;
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        if (!r_memWe) r_dRdata <= mem_rdata;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_kill  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_ack     = (r_state == RESP) && (r_src == SRC_I) && !r_kill;
    assign d_ack     = (r_state == RESP) && (r_src == SRC_D);
    assign i_rdata   = r_iRdata;
    assign d_rdata   = r_dRdata;
    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk      (clk),
        .reset    (reset),
        .i_iGrant (w_iGrant),
        .i_dGrant (w_dGrant),
        .i_iStall (i_req && !i_ack),
        .o_iGrants(perf_i_grants),
        .o_dGrants(perf_d_grants),
        .o_iStall (perf_i_stall)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays core and a registered memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_i_stall;
    int          stallModel = 0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_i_grants(perf_i_grants),
        .perf_d_grants(perf_d_grants),
        .perf_i_stall (perf_i_stall)
`endif
    );

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task tick();
`ifdef MEM_ARB_PERF_EN
        if (reset && i_req && !i_ack) stallModel++;
`endif
        @(posedge clk);
        #1;
    endtask

    // Registered memory: ack arrives waits+1 cycles after mem_req is first seen.
    task serveBus(input int waits, input logic [31:0] rdata, input int flushAt);
        for (int i = 0; i <= waits; i++) begin
            tick();
            checkOutput("busHold", 32'(mem_req), 32'd1);
            flush = (i == flushAt);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        flush     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        checkOutput("rstMemReq", 32'(mem_req), 32'd0);
        checkOutput("rstMemWe", 32'(mem_we), 32'd0);
        checkOutput("rstIAck", 32'(i_ack), 32'd0);
        checkOutput("rstDAck", 32'(d_ack), 32'd0);
        checkOutput("rstMemAddr", mem_addr, 32'h0);
        checkOutput("rstIRdata", i_rdata, 32'h0);
        reset = 1'b1;
        tick();

        // Reset asserted in the middle of a data transaction
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1111;
        tick();
        checkOutput("rstDGrant", 32'(mem_req), 32'd1);
        #3 reset = 1'b0;
        #1;
        checkOutput("rstAsyncDrop", 32'(mem_req), 32'd0);
        checkOutput("rstAsyncWe", 32'(mem_we), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rstRelMemReq", 32'(mem_req), 32'd0);
        checkOutput("rstRelDAck", 32'(d_ack), 32'd0);
        checkOutput("rstRelIAck", 32'(i_ack), 32'd0);

        // Single fetch: mem_addr one cycle after request, i_ack three cycles after
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        checkOutput("fetchMemReq", 32'(mem_req), 32'd1);
        checkOutput("fetchMemAddr", mem_addr, 32'h40);
        checkOutput("fetchMemWe", 32'(mem_we), 32'd0);
        serveBus(0, 32'h2002000A, -1);
        checkOutput("fetchIAck", 32'(i_ack), 32'd1);
        checkOutput("fetchIRdata", i_rdata, 32'h2002000A);
        checkOutput("fetchDAck", 32'(d_ack), 32'd0);
        checkOutput("fetchMemReqDrop", 32'(mem_req), 32'd0);
        i_req = 1'b0;
        tick();
        checkOutput("fetchIAckPulse", 32'(i_ack), 32'd0);

        // Collision: the data write wins, the fetch follows without bus overlap
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        tick();
        checkOutput("collMemReq", 32'(mem_req), 32'd1);
        checkOutput("collMemWe", 32'(mem_we), 32'd1);
        checkOutput("collMemAddr", mem_addr, 32'h200);
        checkOutput("collMemWdata", mem_wdata, 32'hDEADBEEF);
        serveBus(0, 32'hFFFFFFFF, -1);
        checkOutput("collDAck", 32'(d_ack), 32'd1);
        checkOutput("collIAckEarly", 32'(i_ack), 32'd0);
        checkOutput("collDRdataKept", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        checkOutput("collNoOverlap", 32'(mem_req), 32'd0);
        tick();
        checkOutput("collIGrant", 32'(mem_req), 32'd1);
        checkOutput("collIAddr", mem_addr, 32'h100);
        checkOutput("collIWe", 32'(mem_we), 32'd0);
        serveBus(0, 32'h13572468, -1);
        checkOutput("collIAck", 32'(i_ack), 32'd1);
        checkOutput("collIRdata", i_rdata, 32'h13572468);
        i_req = 1'b0;
        tick();

        // Flush in IDLE holds off the fetch grant for that cycle only
        i_req = 1'b1; i_addr = 32'h140; flush = 1'b1;
        tick();
        checkOutput("flushIdleBlock", 32'(mem_req), 32'd0);
        flush = 1'b0;
        tick();
        checkOutput("flushIdleGrant", 32'(mem_req), 32'd1);
        checkOutput("flushIdleAddr", mem_addr, 32'h140);
        serveBus(0, 32'hCAFE0140, -1);
        checkOutput("flushIdleIAck", 32'(i_ack), 32'd1);
        checkOutput("flushIdleRdata", i_rdata, 32'hCAFE0140);
        i_req = 1'b0;
        tick();

        // Flush while I_BUSY with four wait states: response is dropped
        i_req = 1'b1; i_addr = 32'h180;
        tick();
        checkOutput("flushBusyGrant", 32'(mem_req), 32'd1);
        serveBus(4, 32'hBADBAD00, 1);
        checkOutput("flushBusyNoAck", 32'(i_ack), 32'd0);
        checkOutput("flushBusyRdata", i_rdata, 32'hCAFE0140);
        checkOutput("flushBusyMemReq", 32'(mem_req), 32'd0);
        i_req = 1'b0;
        tick();
        checkOutput("flushBusyStillNoAck", 32'(i_ack), 32'd0);

        i_req = 1'b1; i_addr = 32'h1C0;
        tick();
        checkOutput("refetchAddr", mem_addr, 32'h1C0);
        serveBus(0, 32'h0000ABCD, -1);
        checkOutput("refetchIAck", 32'(i_ack), 32'd1);
        checkOutput("refetchRdata", i_rdata, 32'h0000ABCD);
        i_req = 1'b0;
        tick();

        // Flush on the same edge as mem_ack still kills the fetch
        i_req = 1'b1; i_addr = 32'h240;
        tick();
        checkOutput("coinGrant", 32'(mem_req), 32'd1);
        serveBus(2, 32'h99999999, 2);
        checkOutput("coinNoAck", 32'(i_ack), 32'd0);
        checkOutput("coinRdata", i_rdata, 32'h0000ABCD);
        i_req = 1'b0;
        tick();

        // Write 0x55 to 0x300, then read it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h55;
        tick();
        checkOutput("wrMemWe", 32'(mem_we), 32'd1);
        checkOutput("wrMemAddr", mem_addr, 32'h300);
        checkOutput("wrMemWdata", mem_wdata, 32'h55);
        serveBus(0, 32'h0, -1);
        checkOutput("wrDAck", 32'(d_ack), 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        checkOutput("rdMemWe", 32'(mem_we), 32'd0);
        checkOutput("rdMemAddr", mem_addr, 32'h300);
        serveBus(1, 32'h55, -1);
        checkOutput("rdDAck", 32'(d_ack), 32'd1);
        checkOutput("rdDRdata", d_rdata, 32'h55);
        checkOutput("rdIAck", 32'(i_ack), 32'd0);
        d_req = 1'b0;
        tick();
        checkOutput("rdDAckPulse", 32'(d_ack), 32'd0);

`ifdef MEM_ARB_PERF_EN
        checkOutput("perfIGrants", perf_i_grants, 32'd6);
        checkOutput("perfDGrants", perf_d_grants, 32'd3);
        checkOutput("perfIStall", perf_i_stall, 32'(stallModel));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
